balance_ctrl: RTL and testbench
===============================

BALANCE_CTRL -- requirements
Module: balance_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYC, default 100000000, meaning clock cycles per 1 s charge tick.
REQ-002 SHALL have parameter DEB_CYC, default 2000000, meaning cycles a button must be stable to register (20 ms).
REQ-003 SHALL have parameter BAL_MAX, default 999, meaning saturating upper balance.
REQ-004 SHALL have parameter BAL_MIN, default -99, meaning saturating lower balance (arrears floor).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port btn_add1  input  1  raw top-up button, +1 unit per press.
REQ-008 SHALL have port btn_add10  input  1  raw top-up button, +10 units per press.
REQ-009 SHALL have port charge_en  input  1  level from wash controller, high while washing (billable).
REQ-010 SHALL have port bal  output  12  signed two's-complement balance fed to wash controller.
REQ-011 SHALL have port arrears  output  1  high when bal < 0.
REQ-012 SHALL have port lock  output  1  high when wash must stop (state LOCK).

Function
REQ-013 SHALL debounce each button independently: counter restarts on any raw change; a press is accepted when raw level held high for DEB_CYC consecutive cycles; exactly one add pulse per press, re-armed only after button held low for DEB_CYC cycles.
REQ-014 SHALL apply an accepted press one cycle after acceptance: bal <= min(bal + amount, BAL_MAX), computed at 13-bit width, no wrap.
REQ-015 SHALL run a tick counter 0..TICK_CYC-1 only in state CHARGE; counter clears on leaving CHARGE; tick pulses for one cycle when counter = TICK_CYC-1.
REQ-016 SHALL implement FSM states IDLE, CHARGE, LOCK.
REQ-017 SHALL transition IDLE -> CHARGE when charge_en=1 and bal > 0; IDLE stays IDLE if charge_en=1 and bal <= 0, with lock asserted combinationally from bal <= 0 and charge_en.
REQ-018 SHALL in CHARGE decrement bal by 1 on each tick, saturating at BAL_MIN; CHARGE -> IDLE when charge_en=0; CHARGE -> LOCK when bal reaches BAL_MIN.
REQ-019 SHALL in LOCK hold lock=1, no decrement; LOCK -> IDLE when bal > 0 after top-up (charge_en ignored).
REQ-020 SHALL, when a top-up and a tick coincide in the same cycle, apply both: bal <= sat(bal + amount - 1); if both buttons accept in the same cycle, amount = 11.
REQ-021 SHALL let charge_en falling in the same cycle as a tick still apply that tick's decrement.
REQ-022 SHALL drive arrears combinationally from bal[11]; lock = (state==LOCK) | (charge_en & bal<=0 & state==IDLE).

Reset
REQ-023 SHALL on rst=1 immediately force bal=0, state=IDLE, tick and debounce counters=0, debounce armed, arrears=0, lock=0, regardless of clock.
REQ-024 SHALL, if reset is asserted mid-press, require a full new DEB_CYC stable period after release of reset before accepting that press.
REQ-025 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification (TICK_CYC=10, DEB_CYC=4)
REQ-026 SHALL cover: btn_add10 high 6 cycles from reset -> bal=10 exactly once; hold 20 more cycles -> bal stays 10.
REQ-027 SHALL cover: btn_add1 glitch high 3 cycles then low -> bal unchanged at 0.
REQ-028 SHALL cover: bal=3, charge_en=1 for 60 cycles -> bal 2,1,0,-1,-2 at 10-cycle spacing, arrears=1 after bal=-1.
REQ-029 SHALL cover: bal=-98 in CHARGE, one tick -> bal=-99, lock=1, state LOCK; further ticks none; add10 press -> bal=-89, still LOCK; ten add10 presses -> bal=11, lock=0.
REQ-030 SHALL cover: bal=995, add10 press -> bal=999; add1 coinciding with tick at bal=999 -> bal=999.
REQ-031 SHALL cover: rst pulsed asynchronously mid-CHARGE at bal=57 -> bal=0, lock=0, arrears=0 before next clk edge.

Source files
------------

// File: rtl/balance_ctrl.sv
// -----------------------------------------------------------------------------
// balance_ctrl
//   Prepaid balance keeper for a wash bay. Two raw top-up buttons (+1, +10)
//   are debounced independently and credited to a signed 12-bit balance.
//   While the wash controller reports billable time (charge_en), one unit is
//   charged per TICK_CYC clock cycles. The balance saturates at BAL_MAX and
//   BAL_MIN. Reaching the arrears floor while charging locks the bay until a
//   top-up brings the balance above zero again.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   btn_add1   in   raw top-up button, +1 unit per accepted press
//   btn_add10  in   raw top-up button, +10 units per accepted press
//   charge_en  in   high while washing (billable)
//   bal        out  signed two's-complement balance
//   arrears    out  high while bal < 0
//   lock       out  high when the wash must stop
// -----------------------------------------------------------------------------
module balance_ctrl #(
    parameter int TICK_CYC = 100000000,
    parameter int DEB_CYC  = 2000000,
    parameter int BAL_MAX  = 999,
    parameter int BAL_MIN  = -99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_add1,
    input  logic               btn_add10,
    input  logic               charge_en,
    output logic signed [11:0] bal,
    output logic               arrears,
    output logic               lock
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    localparam logic [DW-1:0]        DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [DW-1:0]        DEB_FULL  = DW'(DEB_CYC);
    localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_CYC - 1);
    localparam logic signed [12:0]   MAX13     = 13'(BAL_MAX);
    localparam logic signed [12:0]   MIN13     = 13'(BAL_MIN);
    localparam logic signed [11:0]   MIN12     = 12'(BAL_MIN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHARGE = 2'd1,
        S_LOCK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic signed [11:0] bal_q, bal_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               tick;

    // Index 0 is the +1 button, index 1 the +10 button.
    logic [1:0]         raw;
    logic [1:0]         raw_q;
    logic [1:0]         armed_q, armed_d;
    logic [1:0]         acc_q, acc_d;
    logic [DW-1:0]      dcnt_q [2];
    logic [DW-1:0]      dcnt_d [2];

    logic signed [12:0] amt;
    logic signed [12:0] sum;

    // Clamp a 13-bit intermediate into the legal balance range.
    function automatic logic signed [11:0] sat_bal(input logic signed [12:0] v);
        if (v > MAX13) begin
            return 12'(MAX13);
        end else if (v < MIN13) begin
            return 12'(MIN13);
        end else begin
            return 12'(v);
        end
    endfunction

    assign raw = {btn_add10, btn_add1};

    // dcnt counts consecutive samples at the current raw level, saturating at
    // DEB_CYC. A high run reaching DEB_CYC fires one accept if armed; a low run
    // reaching DEB_CYC re-arms. A level change restarts the run at 1, so after
    // reset (raw_q cleared) a held button needs a complete new stable period.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i]  = dcnt_q[i];
            armed_d[i] = armed_q[i];
            acc_d[i]   = 1'b0;
            if (raw[i] != raw_q[i]) begin
                dcnt_d[i] = DW'(1);
            end else if (dcnt_q[i] != DEB_FULL) begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
                if (dcnt_q[i] == DEB_LAST) begin
                    if (raw[i] && armed_q[i]) begin
                        acc_d[i]   = 1'b1;
                        armed_d[i] = 1'b0;
                    end else if (!raw[i]) begin
                        armed_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign tick = (state_q == S_CHARGE) && (tcnt_q == TICK_LAST);

    // Top-ups and the charge tick combine into one saturated update.
    always_comb begin
        amt = 13'sd0;
        if (acc_q[0]) begin
            amt = amt + 13'sd1;
        end
        if (acc_q[1]) begin
            amt = amt + 13'sd10;
        end
        sum   = 13'(bal_q) + amt - (tick ? 13'sd1 : 13'sd0);
        bal_d = sat_bal(sum);
    end

    // Exits look at the updated balance so that bal and state move together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (charge_en && (bal_q > 12'sd0)) begin
                    state_d = S_CHARGE;
                end
            end
            S_CHARGE: begin
                if (bal_d == MIN12) begin
                    state_d = S_LOCK;
                end else if (!charge_en) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                if (bal_d > 12'sd0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tcnt_d = '0;
        if ((state_q == S_CHARGE) && (state_d == S_CHARGE) && !tick) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bal_q   <= '0;
            tcnt_q  <= '0;
            raw_q   <= '0;
            armed_q <= '1;
            acc_q   <= '0;
            dcnt_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            bal_q   <= bal_d;
            tcnt_q  <= tcnt_d;
            raw_q   <= raw;
            armed_q <= armed_d;
            acc_q   <= acc_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign bal     = bal_q;
    assign arrears = bal_q[11];
    // Gated by rst so lock drops immediately even if charge_en is still high.
    assign lock    = ~rst & ((state_q == S_LOCK) |
                             (charge_en & (bal_q <= 12'sd0) & (state_q == S_IDLE)));

endmodule

// File: tb/tb_balance_ctrl.sv
// -----------------------------------------------------------------------------
// tb_balance_ctrl
//   Directed bench for balance_ctrl with TICK_CYC=10, DEB_CYC=4. A behavioural
//   model tracks button run lengths, billable time and the balance in plain
//   integers; a compare process checks bal/arrears/lock against it on every
//   falling edge, and literal expectations pin both DUT and model at key
//   points of each scenario.
// -----------------------------------------------------------------------------
module tb_balance_ctrl;

    localparam int TICK_CYC = 10;
    localparam int DEB_CYC  = 4;
    localparam int BAL_MAX  = 999;
    localparam int BAL_MIN  = -99;

    localparam int M_IDLE   = 0;
    localparam int M_CHARGE = 1;
    localparam int M_LOCK   = 2;

    logic               clk;
    logic               rst;
    logic               btn_add1;
    logic               btn_add10;
    logic               charge_en;
    logic signed [11:0] bal;
    logic               arrears;
    logic               lock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    balance_ctrl #(
        .TICK_CYC (TICK_CYC),
        .DEB_CYC  (DEB_CYC),
        .BAL_MAX  (BAL_MAX),
        .BAL_MIN  (BAL_MIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_add1  (btn_add1),
        .btn_add10 (btn_add10),
        .charge_en (charge_en),
        .bal       (bal),
        .arrears   (arrears),
        .lock      (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_bal;
    int m_state;
    int m_billed;        // cycles spent in CHARGE since entering it
    int m_lvl   [2];
    int m_run   [2];
    bit m_armed [2];
    bit m_pend  [2];

    always @(posedge clk or posedge rst) begin : model
        int amount;
        int tck;
        int nb;
        int rv [2];
        int prev_state;
        if (rst) begin
            m_bal    = 0;
            m_state  = M_IDLE;
            m_billed = 0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b]   = 0;
                m_run[b]   = 0;
                m_armed[b] = 1'b1;
                m_pend[b]  = 1'b0;
            end
        end else begin
            rv[0]  = int'(btn_add1);
            rv[1]  = int'(btn_add10);
            amount = (m_pend[0] ? 1 : 0) + (m_pend[1] ? 10 : 0);
            tck    = (m_state == M_CHARGE && (m_billed % TICK_CYC) == TICK_CYC - 1) ? 1 : 0;
            nb     = m_bal + amount - tck;
            if (nb > BAL_MAX) nb = BAL_MAX;
            if (nb < BAL_MIN) nb = BAL_MIN;
            prev_state = m_state;
            if (m_state == M_IDLE) begin
                if (charge_en && m_bal > 0) m_state = M_CHARGE;
            end else if (m_state == M_CHARGE) begin
                if (nb == BAL_MIN) m_state = M_LOCK;
                else if (!charge_en) m_state = M_IDLE;
            end else begin
                if (nb > 0) m_state = M_IDLE;
            end
            m_billed = (prev_state == M_CHARGE && m_state == M_CHARGE) ? m_billed + 1 : 0;
            m_bal = nb;
            for (int b = 0; b < 2; b++) begin
                m_pend[b] = 1'b0;
                if (rv[b] != m_lvl[b]) begin
                    m_lvl[b] = rv[b];
                    m_run[b] = 1;
                end else if (m_run[b] < 1000) begin
                    m_run[b] = m_run[b] + 1;
                end
                if (m_lvl[b] == 1 && m_run[b] == DEB_CYC && m_armed[b]) begin
                    m_pend[b]  = 1'b1;
                    m_armed[b] = 1'b0;
                end
                if (m_lvl[b] == 0 && m_run[b] >= DEB_CYC) m_armed[b] = 1'b1;
            end
        end
    end

    function automatic int model_lock();
        if (rst) return 0;
        if (m_state == M_LOCK) return 1;
        if (m_state == M_IDLE && charge_en && m_bal <= 0) return 1;
        return 0;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic lit_bal(input string name, input int exp);
        chk({name, "_dut"}, int'(bal), exp);
        chk({name, "_model"}, m_bal, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_bal", int'(bal), m_bal);
            chk("cyc_arrears", int'(arrears), (m_bal < 0) ? 1 : 0);
            chk("cyc_lock", int'(lock), model_lock());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input bit a1, input bit a10);
        btn_add1  = a1;
        btn_add10 = a10;
        step(6);
        btn_add1  = 1'b0;
        btn_add10 = 1'b0;
        step(6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at %0t: actual=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        btn_add1  = 1'b0;
        btn_add10 = 1'b0;
        charge_en = 1'b0;
        #3;
        chk("reset_bal", int'(bal), 0);
        chk("reset_arrears", int'(arrears), 0);
        chk("reset_lock", int'(lock), 0);
        step(2);
        rst    = 1'b0;
        chk_en = 1'b1;
        step(1);

        // glitch shorter than the debounce window is ignored
        btn_add1 = 1'b1;
        step(3);
        btn_add1 = 1'b0;
        step(8);
        lit_bal("glitch", 0);

        // long add10 press credits exactly once, four samples + one apply cycle
        btn_add10 = 1'b1;
        step(4);
        lit_bal("add10_latency", 0);
        step(1);
        lit_bal("add10_first", 10);
        step(20);
        lit_bal("add10_held", 10);
        btn_add10 = 1'b0;
        step(6);

        // charging from 3 into arrears
        do_reset();
        repeat (3) press(1'b1, 1'b0);
        lit_bal("topup3", 3);
        charge_en = 1'b1;
        step(10);
        lit_bal("chg_pre_tick", 3);
        step(1);
        lit_bal("chg_t1", 2);
        step(10);
        lit_bal("chg_t2", 1);
        step(10);
        lit_bal("chg_t3", 0);
        chk("chg_arrears_at0", int'(arrears), 0);
        step(10);
        lit_bal("chg_t4", -1);
        chk("chg_arrears_neg", int'(arrears), 1);
        step(10);
        lit_bal("chg_t5", -2);
        step(9);
        lit_bal("chg_60cyc", -2);
        charge_en = 1'b0;          // falls right before the next tick edge
        step(1);
        lit_bal("fall_with_tick", -3);
        step(5);
        lit_bal("idle_hold", -3);
        charge_en = 1'b1;
        step(2);
        chk("idle_lock_nonpos", int'(lock), 1);
        lit_bal("idle_no_charge", -3);
        charge_en = 1'b0;
        step(1);
        chk("idle_unlock", int'(lock), 0);

        // run down to the floor and lock
        do_reset();
        press(1'b1, 1'b0);
        lit_bal("floor_start", 1);
        charge_en = 1'b1;
        step(1000);
        lit_bal("floor_m98", -98);
        chk("floor_lock_pre", int'(lock), 0);
        step(1);
        lit_bal("floor_m99", -99);
        chk("floor_lock", int'(lock), 1);
        chk("floor_arrears", int'(arrears), 1);
        step(30);
        lit_bal("floor_no_more_ticks", -99);
        press(1'b0, 1'b1);
        lit_bal("lock_topup1", -89);
        chk("lock_still", int'(lock), 1);
        charge_en = 1'b0;
        step(2);
        chk("lock_ignores_en", int'(lock), 1);
        repeat (10) press(1'b0, 1'b1);
        lit_bal("lock_release", 11);
        chk("lock_cleared", int'(lock), 0);

        // upper saturation and top-up coinciding with a tick
        do_reset();
        press(1'b1, 1'b1);
        lit_bal("both_buttons", 11);
        repeat (89) press(1'b1, 1'b1);
        lit_bal("both_x90", 990);
        repeat (5) press(1'b1, 1'b0);
        lit_bal("to_995", 995);
        press(1'b0, 1'b1);
        lit_bal("sat_999", 999);
        charge_en = 1'b1;
        step(6);
        btn_add1 = 1'b1;
        step(4);
        lit_bal("coincide_pre", 999);
        step(1);
        lit_bal("coincide", 999);
        btn_add1 = 1'b0;
        step(10);
        lit_bal("max_next_tick", 998);
        step(9);
        charge_en = 1'b0;
        step(1);
        lit_bal("max_fall_tick", 997);
        step(5);
        lit_bal("max_idle", 997);

        // asynchronous reset mid-charge with a press in flight
        do_reset();
        repeat (5) press(1'b1, 1'b1);
        repeat (2) press(1'b1, 1'b0);
        charge_en = 1'b1;
        step(5);
        lit_bal("pre_rst_57", 57);
        chk("pre_rst_lock", int'(lock), 0);
        btn_add1 = 1'b1;
        step(2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_bal", int'(bal), 0);
        chk("async_rst_lock", int'(lock), 0);
        chk("async_rst_arrears", int'(arrears), 0);
        charge_en = 1'b0;
        step(2);
        rst = 1'b0;
        step(4);
        lit_bal("rst_press_wait", 0);
        step(1);
        lit_bal("rst_press_accept", 1);
        btn_add1 = 1'b0;
        step(6);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
